// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl
//  Description : Pong match controller. Synchronises the start button, detects
//                score-flag rising edges from the ball stage, keeps both
//                scores and runs the IDLE/PLAY/POINT/OVER match FSM. Drives
//                the state bus and a one-cycle ball re-serve pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module game_ctrl #(
   parameter int WIN_SCORE    = 9,
   parameter int PAUSE_FRAMES = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic       score1_in,
   input  logic       score2_in,
   output logic [1:0] state,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] winner,
   output logic       ball_rst
);

   localparam int             PW         = $clog2(PAUSE_FRAMES + 1);
   localparam logic [3:0]     WIN_VAL    = 4'(WIN_SCORE);
   localparam logic [PW-1:0]  PAUSE_LOAD = PW'(PAUSE_FRAMES);
   localparam logic [PW-1:0]  PAUSE_ONE  = PW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      POINT = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t        cur_state, next_state;
   logic [PW-1:0] pause_cnt, pause_nxt;
   logic [3:0]    p1_nxt, p2_nxt;
   logic [1:0]    winner_nxt;
   logic          ball_rst_nxt;

   logic          start_s1, start_s2, start_s3;
   logic          score1_d, score2_d;
   logic          start_evt, s1_evt, s2_evt;
   logic [3:0]    p1_inc, p2_inc;

   // Start button: two-flop synchroniser plus a third flop for edge detection;
   // score flags delayed one cycle in every state so a held level counts once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
         start_s3 <= 1'b0;
         score1_d <= 1'b0;
         score2_d <= 1'b0;
      end else begin
         start_s1 <= start;
         start_s2 <= start_s1;
         start_s3 <= start_s2;
         score1_d <= score1_in;
         score2_d <= score2_in;
      end
   end

   assign start_evt = start_s2 & ~start_s3;
   assign s1_evt    = score1_in & ~score1_d;
   assign s2_evt    = score2_in & ~score2_d;
   assign p1_inc    = p1_score + 4'd1;
   assign p2_inc    = p2_score + 4'd1;
   assign state     = cur_state;

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= IDLE;
         pause_cnt <= '0;
         p1_score  <= 4'd0;
         p2_score  <= 4'd0;
         winner    <= 2'b00;
         ball_rst  <= 1'b0;
      end else begin
         cur_state <= next_state;
         pause_cnt <= pause_nxt;
         p1_score  <= p1_nxt;
         p2_score  <= p2_nxt;
         winner    <= winner_nxt;
         ball_rst  <= ball_rst_nxt;
      end
   end

   // Next-state and next-output logic; player 1 takes priority on a tie.
   always_comb begin
      next_state   = cur_state;
      pause_nxt    = pause_cnt;
      p1_nxt       = p1_score;
      p2_nxt       = p2_score;
      winner_nxt   = winner;
      ball_rst_nxt = 1'b0;
      case (cur_state)
         IDLE: begin
            if (start_evt) begin
               next_state   = PLAY;
               p1_nxt       = 4'd0;
               p2_nxt       = 4'd0;
               winner_nxt   = 2'b00;
               ball_rst_nxt = 1'b1;
            end
         end
         PLAY: begin
            if (s1_evt) begin
               p1_nxt = p1_inc;
               if (p1_inc == WIN_VAL) begin
                  next_state = OVER;
                  winner_nxt = 2'b01;
               end else begin
                  next_state = POINT;
                  pause_nxt  = PAUSE_LOAD;
               end
            end else if (s2_evt) begin
               p2_nxt = p2_inc;
               if (p2_inc == WIN_VAL) begin
                  next_state = OVER;
                  winner_nxt = 2'b10;
               end else begin
                  next_state = POINT;
                  pause_nxt  = PAUSE_LOAD;
               end
            end
         end
         POINT: begin
            if (frame_tick) begin
               if (pause_cnt == PAUSE_ONE) begin
                  next_state   = PLAY;
                  pause_nxt    = '0;
                  ball_rst_nxt = 1'b1;
               end else begin
                  pause_nxt = pause_cnt - PAUSE_ONE;
               end
            end
         end
         OVER: begin
            if (start_evt) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_ctrl
//  Description : Directed self-checking bench for game_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       frame_tick = 1'b0;
   logic       score1_in = 1'b0;
   logic       score2_in = 1'b0;
   logic [1:0] state;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;
   logic       ball_rst;

   int n_assert = 0;
   int n_fail   = 0;

   game_ctrl #(.WIN_SCORE(9), .PAUSE_FRAMES(120)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_tick (frame_tick),
      .score1_in  (score1_in),
      .score2_in  (score2_in),
      .state      (state),
      .p1_score   (p1_score),
      .p2_score   (p2_score),
      .winner     (winner),
      .ball_rst   (ball_rst)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         tick();
      end
   endtask

   task automatic pulse2();
      score2_in = 1'b1;
      tick();
      score2_in = 1'b0;
      tick();
   endtask

   // Start pressed from scratch; returns right after the edge that acts on it.
   task automatic press_start();
      start = 1'b1;
      repeat (3) tick();
   endtask

   task automatic release_start();
      repeat (2) tick();
      start = 1'b0;
      repeat (3) tick();
   endtask

   // Directed sequence.
   initial begin
      repeat (2) tick();
      check("rst_state", 8'(state), 8'h0);
      check("rst_p1", 8'(p1_score), 8'h0);
      check("rst_p2", 8'(p2_score), 8'h0);
      check("rst_winner", 8'(winner), 8'h0);
      check("rst_ball_rst", 8'(ball_rst), 8'h0);
      reset = 1'b0;
      tick();

      // 1: start reaches the FSM on the third edge.
      start = 1'b1;
      tick();
      check("start_edge1", 8'(state), 8'h0);
      tick();
      check("start_edge2", 8'(state), 8'h0);
      tick();
      check("start_edge3", 8'(state), 8'h1);
      check("start_ball_rst_hi", 8'(ball_rst), 8'h1);
      tick();
      check("start_ball_rst_lo", 8'(ball_rst), 8'h0);
      check("start_p1", 8'(p1_score), 8'h0);
      tick();
      start = 1'b0;
      repeat (3) tick();
      check("start_ignored_play", 8'(state), 8'h1);
      frames(2);
      check("frame_in_play", 8'(state), 8'h1);

      // 2: held score1 counts once; pause of 120 frames.
      score1_in = 1'b1;
      tick();
      check("p1_first", 8'(p1_score), 8'h1);
      check("state_point", 8'(state), 8'h2);
      check("no_ball_rst_on_score", 8'(ball_rst), 8'h0);
      frames(119);
      check("pause_119", 8'(state), 8'h2);
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("pause_done", 8'(state), 8'h1);
      check("reserve_ball_rst_hi", 8'(ball_rst), 8'h1);
      tick();
      check("reserve_ball_rst_lo", 8'(ball_rst), 8'h0);
      check("p1_held_level", 8'(p1_score), 8'h1);
      check("state_held_level", 8'(state), 8'h1);
      score1_in = 1'b0;
      tick();

      // 3: score2 ignored while in POINT.
      pulse2();
      check("p2_first", 8'(p2_score), 8'h1);
      pulse2();
      check("p2_in_point", 8'(p2_score), 8'h1);
      check("state_in_point", 8'(state), 8'h2);
      frames(120);
      check("back_to_play", 8'(state), 8'h1);

      // 4: simultaneous events, player 1 wins the tie.
      score1_in = 1'b1;
      score2_in = 1'b1;
      tick();
      check("tie_p1", 8'(p1_score), 8'h2);
      check("tie_p2", 8'(p2_score), 8'h1);
      score1_in = 1'b0;
      score2_in = 1'b0;
      tick();
      frames(120);
      check("tie_back_play", 8'(state), 8'h1);
      check("tie_p2_after", 8'(p2_score), 8'h1);

      // 5: player 2 reaches 9 and wins.
      repeat (7) begin
         pulse2();
         frames(120);
      end
      check("p2_eight", 8'(p2_score), 8'h8);
      check("state_before_win", 8'(state), 8'h1);
      score2_in = 1'b1;
      tick();
      check("p2_nine", 8'(p2_score), 8'h9);
      check("state_over", 8'(state), 8'h3);
      check("winner_p2", 8'(winner), 8'h2);
      score2_in = 1'b0;
      tick();
      frames(3);
      score1_in = 1'b1;
      tick();
      score1_in = 1'b0;
      tick();
      check("over_hold_state", 8'(state), 8'h3);
      check("over_hold_p1", 8'(p1_score), 8'h2);
      press_start();
      check("over_to_idle", 8'(state), 8'h0);
      check("idle_keep_p2", 8'(p2_score), 8'h9);
      check("idle_keep_winner", 8'(winner), 8'h2);
      release_start();
      press_start();
      check("restart_state", 8'(state), 8'h1);
      check("restart_p1", 8'(p1_score), 8'h0);
      check("restart_p2", 8'(p2_score), 8'h0);
      check("restart_winner", 8'(winner), 8'h0);
      check("restart_ball_rst", 8'(ball_rst), 8'h1);
      release_start();

      // 6: asynchronous reset in the middle of a pause.
      score1_in = 1'b1;
      tick();
      score1_in = 1'b0;
      check("pre_reset_point", 8'(state), 8'h2);
      tick();
      frames(63);
      check("pre_reset_still_point", 8'(state), 8'h2);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_state", 8'(state), 8'h0);
      check("async_p1", 8'(p1_score), 8'h0);
      check("async_winner", 8'(winner), 8'h0);
      check("async_ball_rst", 8'(ball_rst), 8'h0);
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      check("reset_no_glitch", 8'(ball_rst), 8'h0);
      reset = 1'b0;
      frames(2);
      check("post_reset_idle", 8'(state), 8'h0);
      check("post_reset_ball_rst", 8'(ball_rst), 8'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
